// File: rtl/game_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : game_pkg                                              |
// | Brief    : Shared state encoding and screen/frame defaults.      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package game_pkg;

  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_SCREEN_H    = 120;
  localparam int DEF_FRAME_TICKS = 833334;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SHIP_UPD  = 3'd2,
    ST_GRID_UPD  = 3'd3,
    ST_DRAW      = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : frame_tick_gen                                        |
// | Brief    : Free-running frame counter with hold; one-cycle tick. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module frame_tick_gen
  import game_pkg::*;
#(
  parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int            CW     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (hold || (count_q == C_LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by hold so a stale count on the first held cycle never fires.
  assign tick = ~hold & (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/game_frame_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : game_frame_sequencer                                  |
// | Brief    : Frame pacing, update-enable sequencing, pixel sweep.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       vga_ready,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       game_reset,
  output logic       plot,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       frame_done,
  output logic       overrun,
  output logic       game_over
);

  localparam logic [7:0] C_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] C_Y_LAST = 7'(SCREEN_H - 1);

  state_t     state_q;
  logic       start_q;
  logic       pending_q;
  logic       hit_latched_q;
  logic       ship_en_q;
  logic       grid_en_q;
  logic       game_reset_q;
  logic       plot_q;
  logic       frame_done_q;
  logic       overrun_q;
  logic       game_over_q;
  logic [7:0] draw_x_q;
  logic [6:0] draw_y_q;

  logic w_hold;
  logic w_tick;
  logic w_start_rise;
  logic w_accept;
  logic w_last_pix;
  logic w_tick_extra;
  logic w_pending_set;
  logic w_hit_seen;

  assign w_hold        = (state_q == ST_IDLE) || (state_q == ST_GAME_OVER);
  assign w_start_rise  = start & ~start_q;
  assign w_accept      = plot_q & vga_ready;
  assign w_last_pix    = w_accept && (draw_x_q == C_X_LAST) && (draw_y_q == C_Y_LAST);
  assign w_tick_extra  = w_tick & (state_q != ST_WAIT_TICK);
  assign w_pending_set = pending_q | w_tick_extra;
  assign w_hit_seen    = hit_latched_q | (hit & ~w_hold);

  frame_tick_gen #(
    .FRAME_TICKS (FRAME_TICKS)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .hold  (w_hold),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      pending_q     <= 1'b0;
      hit_latched_q <= 1'b0;
      ship_en_q     <= 1'b0;
      grid_en_q     <= 1'b0;
      game_reset_q  <= 1'b0;
      plot_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      game_over_q   <= 1'b0;
      draw_x_q      <= 8'd0;
      draw_y_q      <= 7'd0;
    end else begin
      start_q       <= start;
      ship_en_q     <= 1'b0;
      grid_en_q     <= 1'b0;
      game_reset_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      // Only one frame may be queued; a further early tick is dropped.
      overrun_q     <= w_tick_extra & pending_q;
      pending_q     <= w_pending_set;
      hit_latched_q <= w_hit_seen;

      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (w_start_rise) begin
            state_q       <= ST_WAIT_TICK;
            game_reset_q  <= 1'b1;
            game_over_q   <= 1'b0;
            hit_latched_q <= 1'b0;
            pending_q     <= 1'b0;
          end
        end
        ST_WAIT_TICK: begin
          if (w_tick || pending_q) begin
            state_q   <= ST_SHIP_UPD;
            ship_en_q <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        ST_SHIP_UPD: begin
          state_q   <= ST_GRID_UPD;
          grid_en_q <= 1'b1;
        end
        ST_GRID_UPD: begin
          state_q  <= ST_DRAW;
          plot_q   <= 1'b1;
          draw_x_q <= 8'd0;
          draw_y_q <= 7'd0;
        end
        ST_DRAW: begin
          if (w_last_pix) begin
            plot_q       <= 1'b0;
            frame_done_q <= 1'b1;
            if (w_hit_seen) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else if (w_pending_set) begin
              state_q   <= ST_SHIP_UPD;
              ship_en_q <= 1'b1;
              pending_q <= 1'b0;
            end else begin
              state_q <= ST_WAIT_TICK;
            end
          end else if (w_accept) begin
            if (draw_x_q == C_X_LAST) begin
              draw_x_q <= 8'd0;
              draw_y_q <= draw_y_q + 7'd1;
            end else begin
              draw_x_q <= draw_x_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shipUpdateEn = ship_en_q;
  assign gridUpdateEn = grid_en_q;
  assign game_reset   = game_reset_q;
  assign plot         = plot_q;
  assign draw_x       = draw_x_q;
  assign draw_y       = draw_y_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
  assign game_over    = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_frame_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_game_frame_sequencer                               |
// | Brief    : Scoreboard bench; two instances (slow and fast ticks).|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_game_frame_sequencer;

  localparam int FT_A   = 20000;
  localparam int FT_B   = 5000;
  localparam int SW     = 160;
  localparam int SH     = 120;
  localparam int NPIX   = SW * SH;
  localparam int S_SHIP = 0;
  localparam int S_GRID = 1;
  localparam int S_FD   = 2;
  localparam int S_GRST = 3;

  logic       clk = 1'b0;
  logic [1:0] rst_v, start_v, hit_v, rdy_v;
  logic [1:0] ship_v, grid_v, grst_v, plot_v, fd_v, ovr_v, go_v;
  logic [7:0] dx_v [2];
  logic [6:0] dy_v [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [14:0] exp_q [2][$];
  int   ship_cnt [2] = '{0, 0};
  int   grid_cnt [2] = '{0, 0};
  int   grst_cnt [2] = '{0, 0};
  int   fd_cnt   [2] = '{0, 0};
  int   ovr_cnt  [2] = '{0, 0};
  int   acc_cnt  [2] = '{0, 0};
  int   ship_at  [2] = '{0, 0};
  int   grst_at  [2] = '{0, 0};
  logic fd_due   [2] = '{1'b0, 1'b0};
  logic p_plot   [2] = '{1'b0, 1'b0};
  logic p_rdy    [2] = '{1'b0, 1'b0};
  logic p_ship   [2] = '{1'b0, 1'b0};
  logic p_grid   [2] = '{1'b0, 1'b0};
  logic [7:0] p_x [2];
  logic [6:0] p_y [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_frame_sequencer #(.FRAME_TICKS(FT_A), .SCREEN_W(SW), .SCREEN_H(SH)) u_dut_a (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .hit(hit_v[0]), .vga_ready(rdy_v[0]),
    .shipUpdateEn(ship_v[0]), .gridUpdateEn(grid_v[0]), .game_reset(grst_v[0]),
    .plot(plot_v[0]), .draw_x(dx_v[0]), .draw_y(dy_v[0]), .frame_done(fd_v[0]),
    .overrun(ovr_v[0]), .game_over(go_v[0]));

  game_frame_sequencer #(.FRAME_TICKS(FT_B), .SCREEN_W(SW), .SCREEN_H(SH)) u_dut_b (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .hit(hit_v[1]), .vga_ready(rdy_v[1]),
    .shipUpdateEn(ship_v[1]), .gridUpdateEn(grid_v[1]), .game_reset(grst_v[1]),
    .plot(plot_v[1]), .draw_x(dx_v[1]), .draw_y(dy_v[1]), .frame_done(fd_v[1]),
    .overrun(ovr_v[1]), .game_over(go_v[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Instance A stalls with a 1-0-1 ready pattern over the first three rows.
  initial begin
    int phase = 0;
    rdy_v = 2'b11;
    forever begin
      @(posedge clk); #1;
      phase = (phase + 1) % 3;
      rdy_v[0] = (plot_v[0] && (dy_v[0] < 7'd3)) ? (phase != 1) : 1'b1;
      rdy_v[1] = 1'b1;
    end
  end

  task automatic mon_step(input int i);
    logic [14:0] e;
    if (rst_v[i]) begin
      exp_q[i].delete();
      fd_due[i] = 1'b0;
    end
    if (fd_due[i]) begin
      check_eq("frame_done_after_last", fd_v[i], 1);
      check_eq("plot_low_after_last", plot_v[i], 0);
      fd_due[i] = 1'b0;
    end
    if (ship_v[i]) begin ship_cnt[i]++; ship_at[i] = cyc; end
    if (grst_v[i]) begin grst_cnt[i]++; grst_at[i] = cyc; end
    if (fd_v[i])   fd_cnt[i]++;
    if (ovr_v[i])  ovr_cnt[i]++;
    if (p_grid[i]) check_eq("plot_after_grid", plot_v[i], 1);
    if (grid_v[i]) begin
      grid_cnt[i]++;
      check_eq("ship_before_grid", p_ship[i], 1);
      check_eq("sb_empty_at_frame_start", exp_q[i].size(), 0);
      acc_cnt[i] = 0;
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++)
          exp_q[i].push_back({y[6:0], x[7:0]});
    end
    if (plot_v[i] && p_plot[i] && !p_rdy[i]) begin
      check_eq("stall_hold_x", dx_v[i], p_x[i]);
      check_eq("stall_hold_y", dy_v[i], p_y[i]);
    end
    if (plot_v[i] && rdy_v[i]) begin
      acc_cnt[i]++;
      check_eq("sb_has_pixel", exp_q[i].size() > 0, 1);
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        check_eq("pixel_xy", {dy_v[i], dx_v[i]}, e);
        if (e == {7'(SH - 1), 8'(SW - 1)}) fd_due[i] = 1'b1;
      end
    end
    p_plot[i] = plot_v[i];
    p_rdy[i]  = rdy_v[i];
    p_ship[i] = ship_v[i];
    p_grid[i] = grid_v[i];
    p_x[i]    = dx_v[i];
    p_y[i]    = dy_v[i];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon_step(i);
  end

  function automatic logic sig_of(input int inst, input int sel);
    case (sel)
      S_SHIP:  return ship_v[inst];
      S_GRID:  return grid_v[inst];
      S_FD:    return fd_v[inst];
      S_GRST:  return grst_v[inst];
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int inst, input int sel, input int budget, input string tag,
                          output int n);
    logic seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk); #1;
      n++;
      seen = sig_of(inst, sel);
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic wait_pix(input int inst, input int x, input int y, input int budget,
                          input string tag);
    logic seen = 1'b0;
    int   n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk); #1;
      n++;
      seen = plot_v[inst] && (dx_v[inst] == 8'(x)) && (dy_v[inst] == 7'(y));
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic scen_a();
    int n;
    int t_ship;
    start_v[0] = 1'b1;
    wait_sig(0, S_GRST, 4, "a_game_reset_seen", n);
    check_eq("a_game_reset_latency", n, 2);
    repeat (100) @(posedge clk);
    #1 start_v[0] = 1'b0;
    check_eq("a_single_game_reset", grst_cnt[0], 1);
    wait_sig(0, S_SHIP, FT_A + 10, "a_ship_seen", n);
    check_eq("a_reset_to_ship", ship_at[0] - grst_at[0], FT_A);
    t_ship = ship_at[0];
    wait_sig(0, S_GRID, 2, "a_grid_seen", n);
    check_eq("a_grid_after_ship", n, 1);
    wait_sig(0, S_FD, FT_A, "a_frame_done_seen", n);
    check_eq("a_accepts", acc_cnt[0], NPIX);
    check_eq("a_no_ship_at_done", ship_v[0], 0);
    check_eq("a_no_game_over", go_v[0], 0);
    check_eq("a_no_overrun", ovr_cnt[0], 0);
    wait_sig(0, S_SHIP, FT_A, "a_ship2_seen", n);
    check_eq("a_frame_period", ship_at[0] - t_ship, FT_A);
    wait_pix(0, 10, 5, 2000, "a_pixel_10_5_seen");
    rst_v[0] = 1'b1;
    @(negedge clk); #1;
    check_eq("a_rst_plot", plot_v[0], 0);
    check_eq("a_rst_xy", {dy_v[0], dx_v[0]}, 0);
    check_eq("a_rst_fd", fd_v[0], 0);
    repeat (3) @(posedge clk);
    #1 rst_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_eq("a_idle_plot", plot_v[0], 0);
    check_eq("a_no_extra_frame_done", fd_cnt[0], 1);
  endtask

  task automatic scen_b();
    int n;
    start_v[1] = 1'b1;
    wait_sig(1, S_GRST, 4, "b_game_reset_seen", n);
    @(posedge clk); #1 start_v[1] = 1'b0;
    wait_sig(1, S_SHIP, FT_B + 10, "b_ship_seen", n);
    check_eq("b_reset_to_ship", ship_at[1] - grst_at[1], FT_B);
    wait_sig(1, S_FD, NPIX + 10, "b_frame_done1_seen", n);
    check_eq("b_ship_with_done", ship_v[1], 1);
    check_eq("b_overruns_frame1", ovr_cnt[1], 2);
    check_eq("b_ship_count1", ship_cnt[1], 2);
    wait_pix(1, 40, 60, NPIX, "b_pixel_40_60_seen");
    hit_v[1]   = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk); #1 hit_v[1] = 1'b0;
    wait_sig(1, S_FD, NPIX, "b_frame_done2_seen", n);
    check_eq("b_game_over_at_done", go_v[1], 1);
    check_eq("b_no_ship_at_done", ship_v[1], 0);
    check_eq("b_overruns_frame2", ovr_cnt[1], 5);
    repeat (3 * FT_B + 10) @(negedge clk);
    #1;
    check_eq("b_still_game_over", go_v[1], 1);
    check_eq("b_no_enables_ship", ship_cnt[1], 2);
    check_eq("b_no_enables_grid", grid_cnt[1], 2);
    check_eq("b_held_start_no_restart", grst_cnt[1], 1);
    @(posedge clk); #1 start_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_v[1] = 1'b1;
    wait_sig(1, S_GRST, 4, "b_restart_seen", n);
    check_eq("b_restart_latency", n, 2);
    check_eq("b_game_over_cleared", go_v[1], 0);
    check_eq("b_game_reset_count", grst_cnt[1], 2);
    @(posedge clk); #1 start_v[1] = 1'b0;
  endtask

  initial begin
    rst_v   = 2'b11;
    start_v = 2'b00;
    hit_v   = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_flags", {ship_v[i], grid_v[i], grst_v[i], plot_v[i],
                               fd_v[i], ovr_v[i], go_v[i]}, 0);
      check_eq("reset_draw_xy", {dy_v[i], dx_v[i]}, 0);
    end
    @(posedge clk); #1 rst_v = 2'b00;
    fork
      scen_a();
      scen_b();
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/game_frame_sequencer.md
Name: game_frame_sequencer

Overview:
- Frame-level controller for the Starflux game datapath.
- Paces the game at a fixed frame rate and issues the one-cycle ship-update and grid-update enables in order.
- Then sweeps the 160x120 framebuffer, one pixel per accepted plot handshake, into the VGA adapter.
- Owns the start / game-over lifecycle and the pulse that clears the datapath at game start.

Parameters:
- FRAME_TICKS, 833334, clk cycles per frame (50 MHz / 60 Hz); must be greater than SCREEN_W*SCREEN_H+8 for overrun-free operation.
- SCREEN_W, 160, pixels per row.
- SCREEN_H, 120, rows per frame.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  level from user key; edge-detected internally
- hit  in  1  collision flag from datapath; level, any cycle
- vga_ready  in  1  VGA adapter accepts the current pixel this cycle
- shipUpdateEn  out  1  one-cycle pulse; datapath moves ship/gun
- gridUpdateEn  out  1  one-cycle pulse; datapath shifts grid
- game_reset  out  1  one-cycle pulse; clears datapath state at game start
- plot  out  1  pixel valid to VGA adapter
- draw_x  out  8  pixel column, 0..SCREEN_W-1
- draw_y  out  7  pixel row, 0..SCREEN_H-1
- frame_done  out  1  one-cycle pulse when the last pixel is accepted
- overrun  out  1  one-cycle pulse when a frame tick is dropped
- game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE; all pulses, plot, and game_over 0; draw_x=0, draw_y=0.
  - Tick counter=0; pending=0; hit_latched=0; start_q=0.
- start_rise = start & ~start_q; start_q is registered every cycle.
- Tick counter:
  - Held at 0 in IDLE and GAME_OVER; otherwise counts 0..FRAME_TICKS-1 and wraps.
  - tick is high on the cycle the counter equals FRAME_TICKS-1.
- States: IDLE, WAIT_TICK, SHIP_UPD, GRID_UPD, DRAW, GAME_OVER.
- IDLE: on start_rise -> WAIT_TICK; game_reset=1 in the first WAIT_TICK cycle; hit_latched cleared.
- WAIT_TICK: on tick, or with pending=1 -> SHIP_UPD; pending cleared.
- SHIP_UPD: shipUpdateEn=1 for exactly this one cycle -> GRID_UPD.
- GRID_UPD: gridUpdateEn=1 for exactly this one cycle -> DRAW with draw_x=0, draw_y=0.
- DRAW:
  - plot=1. A pixel is accepted when plot&vga_ready.
  - On accept: draw_x++; at SCREEN_W-1, draw_x wraps to 0 and draw_y++.
  - draw_x/draw_y are stable while vga_ready=0.
  - Accept of (SCREEN_W-1, SCREEN_H-1): frame_done=1 next cycle, plot=0. Next state: GAME_OVER if hit_latched, else SHIP_UPD if pending, else WAIT_TICK.
  - Minimum latency from tick to first plot: 3 cycles.
- Overrun: tick outside WAIT_TICK sets pending. A tick while pending is already 1 pulses overrun and is dropped (pending stays 1; at most one frame is queued).
- hit: sampled in WAIT_TICK, SHIP_UPD, GRID_UPD, and DRAW, and ORed into sticky hit_latched. The current frame always finishes drawing before GAME_OVER.
- GAME_OVER: game_over=1; the datapath receives no enables. On start_rise -> WAIT_TICK with a game_reset pulse; hit_latched and pending cleared.
- Simultaneous events:
  - tick in the same cycle as the last-pixel accept sets pending, then goes directly to SHIP_UPD.
  - start_rise outside IDLE/GAME_OVER is ignored.
- reset mid-DRAW: plot drops on the next edge and the sweep is abandoned; no frame_done.
- Widths: draw_x 8 bits, draw_y 7 bits, tick counter $clog2(FRAME_TICKS) bits, with no overflow beyond the stated wrap points.

Decomposition:
- Package game_pkg holds the state enum (3 bits) and the SCREEN_W / SCREEN_H / FRAME_TICKS defaults shared with the datapath and VGA glue.
- Sub-module frame_tick_gen (counter, hold input, tick output) is natural. The FSM and pixel sweep stay in the top module.

Test Plan:
- reset, then start rise with FRAME_TICKS=20000 and vga_ready=1 -> game_reset pulse. After tick: shipUpdateEn, then gridUpdateEn on consecutive cycles; plot starts 3 cycles after tick; 19200 accepts; frame_done on the cycle after (159,119); back in WAIT_TICK.
- vga_ready toggling 1-0-1 in DRAW -> draw_x/draw_y unchanged on stalled cycles; no pixel skipped or repeated; first row ends at x=159, then x=0, y=1.
- FRAME_TICKS=5000 (shorter than the sweep) -> pending set; after frame_done, SHIP_UPD follows immediately; the second extra tick within one sweep pulses overrun once.
- hit pulsed for 1 cycle mid-DRAW at pixel (40,60) -> sweep completes; frame_done, then game_over=1; no further update enables across 3 ticks; start rise -> game_reset pulse, game_over=0.
- start held high for 100 cycles in IDLE -> exactly one game_reset; start held through GAME_OVER entry does not restart until released and re-pressed.
- reset asserted at pixel (10,5) -> next cycle state IDLE, plot=0, draw_x=0, draw_y=0, no frame_done.
